// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and consumes results; slave is the divider.
interface seq_divider_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_dividend;
  logic [VW-1:0] in_divisor;
  logic          in_signed;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_quot;
  logic [VW-1:0] out_rem;
  logic          out_dz;

  modport master (
    output in_valid, in_dividend, in_divisor, in_signed, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dz
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_signed, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dz
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN to compile in two's-complement operation selected by in_signed.
module seq_divider #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_if.slave    bus
);
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          dz_q, dz_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_quot_q, out_quot_d;
  logic [VW-1:0] out_rem_q, out_rem_d;
  logic          out_dz_q, out_dz_d;

  logic [DW-1:0] a_mag;
  logic [VW-1:0] b_mag;
  logic [DW-1:0] quot_fix;
  logic [VW-1:0] rem_fix;
  logic          div_zero;
  logic [VW:0]   rem_sh;
  logic [VW-1:0] rem_sub;
  logic          rem_ge;

`ifdef DIV_SIGNED_EN
  logic sign_a, sign_b;
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  assign sign_a   = bus.in_signed & bus.in_dividend[DW-1];
  assign sign_b   = bus.in_signed & bus.in_divisor[VW-1];
  assign a_mag    = sign_a ? (~bus.in_dividend + DW'(1)) : bus.in_dividend;
  assign b_mag    = sign_b ? (~bus.in_divisor + VW'(1)) : bus.in_divisor;
  assign quot_fix = neg_q_q ? (~quo_q + DW'(1)) : quo_q;
  assign rem_fix  = neg_r_q ? (~rem_q + VW'(1)) : rem_q;

  // Sign of the result: quotient negated on differing signs, remainder follows the dividend
  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (state_q == IDLE && bus.in_valid) begin
      neg_q_d = sign_a ^ sign_b;
      neg_r_d = sign_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.in_signed;
  assign a_mag    = bus.in_dividend;
  assign b_mag    = bus.in_divisor;
  assign quot_fix = quo_q;
  assign rem_fix  = rem_q;
`endif

  assign div_zero = (bus.in_divisor == '0);

  // One restoring step: shift in the next dividend bit, subtract when it fits
  assign rem_sh  = {rem_q, quo_q[DW-1]};
  assign rem_ge  = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = VW'(rem_sh - {1'b0, dvs_q});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    dz_d        = dz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_dz_d    = out_dz_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Raw dividend is kept on divide-by-zero so its low bits become the remainder
          dz_d       = div_zero;
          quo_d      = div_zero ? bus.in_dividend : a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = div_zero ? FIX : CALC;
        end
      end
      CALC: begin
        quo_d = {quo_q[DW-2:0], rem_ge};
        rem_d = rem_ge ? rem_sub : rem_sh[VW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = FIX;
      end
      FIX: begin
        out_valid_d = 1'b1;
        if (dz_q) begin
          out_quot_d = '1;
          out_rem_d  = quo_q[VW-1:0];
          out_dz_d   = 1'b1;
        end else begin
          out_quot_d = quot_fix;
          out_rem_d  = rem_fix;
          out_dz_d   = 1'b0;
        end
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      dz_q        <= dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dz_q    <= out_dz_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_quot  = out_quot_q;
  assign bus.out_rem   = out_rem_q;
  assign bus.out_dz    = out_dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at DW=VW=16; honours DIV_SIGNED_EN like the RTL.
module tb_seq_divider;
  localparam int unsigned DW       = 16;
  localparam int unsigned VW       = 16;
  localparam int          MAX_WAIT = 100;

  typedef struct packed {
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;
    logic          dz;
    logic [31:0]   lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: truncating signed division via int arithmetic, unsigned otherwise
  function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s);
    exp_t e;
    logic s_eff;
    int   sa, sb;
    s_eff = s;
`ifndef DIV_SIGNED_EN
    s_eff = 1'b0;
`endif
    e.dz  = 1'b0;
    e.lat = 32'(DW + 2);
    if (b == '0) begin
      e.quot = '1;
      e.rem  = a[VW-1:0];
      e.dz   = 1'b1;
      e.lat  = 32'd2;
    end else if (s_eff) begin
      sa     = int'($signed(a));
      sb     = int'($signed(b));
      e.quot = DW'(sa / sb);
      e.rem  = VW'(sa % sb);
    end else begin
      e.quot = a / b;
      e.rem  = a % b;
    end
    return e;
  endfunction

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic s,
                        input int hold, input logic pre);
    exp_t e;
    int   lat;
    int   w;
    w = 0;
    while (!bus.in_ready && w < MAX_WAIT) begin
      @(posedge clk); #1; w++;
    end
    check("ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.out_ready   = pre;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_signed   = s;
    bus.in_valid    = 1'b1;
    sb_q.push_back(model(a, b, s));
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = DW'($urandom);
    bus.in_divisor  = VW'($urandom);
    bus.in_signed   = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < MAX_WAIT) begin
      check("in_ready_busy", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    e = sb_q.pop_front();
    check("latency", 32'(lat), e.lat);
    check("quot", 32'(bus.out_quot), 32'(e.quot));
    check("rem", 32'(bus.out_rem), 32'(e.rem));
    check("dz", 32'(bus.out_dz), 32'(e.dz));
    if (!pre) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid    = 1'b1;
        bus.in_dividend = DW'($urandom);
        bus.in_divisor  = VW'($urandom);
        @(posedge clk); #1;
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_ready", 32'(bus.in_ready), 32'd0);
        check("hold_quot", 32'(bus.out_quot), 32'(e.quot));
        check("hold_rem", 32'(bus.out_rem), 32'(e.rem));
        check("hold_dz", 32'(bus.out_dz), 32'(e.dz));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("consumed_valid", 32'(bus.out_valid), 32'd0);
    check("consumed_ready", 32'(bus.in_ready), 32'd1);
    check("kept_quot", 32'(bus.out_quot), 32'(e.quot));
    check("kept_rem", 32'(bus.out_rem), 32'(e.rem));
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_signed   = 1'b0;
    bus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quot", 32'(bus.out_quot), 32'd0);
    check("rst_rem", 32'(bus.out_rem), 32'd0);
    check("rst_dz", 32'(bus.out_dz), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd100, 16'd7, 1'b0, 0, 1'b0);
    run_op(16'd1234, 16'd0, 1'b0, 0, 1'b0);
    run_op(16'hFFF9, 16'd2, 1'b1, 0, 1'b0);
    run_op(16'h8000, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op(16'd1000, 16'd10, 1'b0, 5, 1'b0);
    run_op(16'd999, 16'd1000, 1'b0, 0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1);
    run_op(16'hFFFF, 16'd1, 1'b0, 0, 1'b0);
    run_op(16'd0, 16'd5, 1'b0, 1, 1'b0);
    run_op(16'h8001, 16'd0, 1'b1, 2, 1'b0);
    run_op(16'hFF85, 16'hFFF6, 1'b1, 0, 1'b0);
    run_op(16'd123, 16'hFFF9, 1'b1, 0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [VW-1:0] b;
      b = (i % 5 == 0) ? '0 : ((i % 3 == 0) ? VW'($urandom_range(1, 15)) : VW'($urandom));
      if (b == '0 && i % 5 != 0) b = 16'd3;
      run_op(DW'($urandom), b, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
             1'($urandom_range(0, 1)));
    end

    // Abort in CALC cycle 7; the preceding op left nonzero outputs behind
    run_op(16'd40000, 16'd9, 1'b0, 0, 1'b1);
    bus.in_dividend = 16'd12345;
    bus.in_divisor  = 16'd7;
    bus.in_signed   = 1'b0;
    bus.in_valid    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("calc_busy", 32'(bus.in_ready), 32'd0);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_quot", 32'(bus.out_quot), 32'd0);
    check("abort_rem", 32'(bus.out_rem), 32'd0);
    check("abort_dz", 32'(bus.out_dz), 32'd0);
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_valid", 32'(bus.out_valid), 32'd0);
    run_op(16'd50000, 16'd3, 1'b0, 0, 1'b0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised sequential restoring divider, one quotient bit per clock, with valid/ready handshakes on both input and output. It generalises the team's first-generation 8-bit unsigned divider: separate dividend and divisor widths, back-pressure, divide-by-zero reporting, and an optional signed mode. It sits in the arithmetic library beside the multipliers as a drop-in long-latency divide unit.

## Interface
- `DW`, 16: dividend and quotient width; legal values are ≥2.
- `VW`, 16: divisor and remainder width; legal range is 2..DW.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands present.
- `in_ready` output 1: block accepts operands; equals (state==IDLE).
- `in_dividend` input DW: dividend.
- `in_divisor` input VW: divisor.
- `in_signed` input 1: two's-complement operation; ignored unless `DIV_SIGNED_EN` is defined.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer takes the result.
- `out_quot` output DW: quotient.
- `out_rem` output VW: remainder.
- `out_dz` output 1: divisor was zero.

## Operation
- Accept: rising edge with `in_valid && in_ready`. The block latches the operand magnitudes, the signs (signed mode only) and the dz flag.
- States:
  - IDLE: on accept, go to FIX if divisor==0, else go to CALC.
  - CALC: runs for exactly DW cycles, processing MSB first. Each cycle:
    - rem = {rem, next dividend bit} in a VW+1-bit working register.
    - If rem ≥ divisor: subtract the divisor and set q bit = 1; else q bit = 0.
    - After the DW-th cycle, go to FIX.
  - FIX: apply sign correction, register the outputs, assert `out_valid`, go to DONE.
  - DONE: hold the outputs. On `out_ready`, drop `out_valid` and go to IDLE.
- Unsigned result: quotient = floor(A/B); remainder = A mod B.
- Signed result (truncating division):
  - The core divides |A| (as unsigned DW bits) by |B| (unsigned VW bits).
  - Quotient is negated when sign(A) != sign(B).
  - Remainder takes the sign of A.
- Signed overflow: MIN/-1 gives quotient = MIN (0x8000 at DW=16) and remainder 0. No flag is raised.
- Divide by zero:
  - out_quot = all ones.
  - out_rem = in_dividend[VW-1:0], unmodified even in signed mode.
  - out_dz = 1.
- `out_dz` is 0 for every nonzero divisor.
- Inputs are don't-care except on the accepting edge. `in_valid` asserted while `in_ready` is low is ignored, not queued.

## Timing
- Reset (async, immediate):
  - state = IDLE, so `in_ready` = 1.
  - `out_valid` = 0.
  - `out_quot` = 0, `out_rem` = 0, `out_dz` = 0.
  - The working registers are cleared.
- Reset mid-operation aborts the division. No result is produced.
- Latency is counted as rising edges from the accepting edge, inclusive, to the edge that raises `out_valid`:
  - DW+2 for a nonzero divisor (18 at DW=16).
  - 2 for divide by zero.
  - Latency is independent of operand values and of signed mode.
- All outputs are registered. `out_quot`, `out_rem` and `out_dz` are stable for as long as `out_valid` is high and `out_ready` is low.
- `out_ready` may be held high in advance. In that case DONE lasts exactly one cycle.
- There is no bypass from DONE to IDLE. `in_ready` rises the cycle after the result is consumed, so the peak rate is one op per DW+3 cycles.
- `out_quot`/`out_rem` keep their last values after consumption; only `out_valid` drops.

## Configuration
- `DIV_SIGNED_EN`:
  - Defined: `in_signed` selects two's-complement operation. The magnitude/negation logic and the sign registers are compiled in.
  - Undefined: `in_signed` is ignored, all operations are unsigned, and the sign logic is absent.
- Latency is identical in both builds; the FIX state always exists.

## Test plan
All cases use DW=16, VW=16.
1. 100/7, unsigned → quot 14, rem 2, dz 0. `out_valid` rises exactly 18 edges after accept. `in_ready` is low throughout.
2. 1234/0 → quot 0xFFFF, rem 0x04D2, dz 1, latency 2 edges.
3. 0xFFF9/2 with `in_signed`=1:
   - With `DIV_SIGNED_EN` → quot 0xFFFD (-3), rem 0xFFFF (-1).
   - Without it → quot 0x7FFC, rem 1.
4. 0x8000/0xFFFF, signed build, `in_signed`=1 → quot 0x8000, rem 0, dz 0.
5. Back-pressure: hold `out_ready`=0 for 5 cycles after `out_valid` → outputs stable, `in_ready` stays 0, and a competing `in_valid` is ignored. Release → `in_ready`=1 on the next cycle, and the following op is accepted.
6. Assert `rst_n`=0 during CALC cycle 7 → all outputs go to 0 immediately and `in_ready`=1. A new 50000/3 op then gives quot 16666, rem 2.
